// File: rtl/d_flipflop_7bit.sv
// Program-counter state register: captures the next address on each rising
// edge and presents it to the ROM as the current instruction address.
// Adds capture enable, synchronous clear, a capture-valid flag and a
// registered change strobe so the PC can be stalled, restarted and monitored.
module d_flipflop_7bit #(
    parameter int WIDTH       = 7,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             q_chg
);

    // Reset/clear value, truncated to the register width.
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_q_chg;

    logic [WIDTH-1:0] w_q_next;
    logic             w_valid_next;
    logic             w_chg_next;

    // Next-state selection: clear beats enable, otherwise hold.
    always_comb begin
        w_q_next     = r_q;
        w_valid_next = r_q_valid;
        if (clr) begin
            w_q_next     = RST_VAL;
            w_valid_next = 1'b1;
        end else if (en) begin
            w_q_next     = d;
            w_valid_next = 1'b1;
        end
        w_chg_next = (w_q_next != r_q);
    end

    // State register; reset acts immediately without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q       <= RST_VAL;
            r_q_valid <= 1'b0;
            r_q_chg   <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_q_valid <= w_valid_next;
            r_q_chg   <= w_chg_next;
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign q_chg   = r_q_chg;

endmodule

// File: tb/tb_d_flipflop_7bit.sv
// Self-checking bench for the PC state register: directed scenarios with
// literal expectations, then randomized stimulus against a behavioural model.
module tb_d_flipflop_7bit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] d;
    logic       en;
    logic       clr;
    logic [6:0] q;
    logic       q_valid;
    logic       q_chg;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the observable outputs.
    logic [6:0] m_q;
    logic       m_valid;
    logic       m_chg;
    logic       cmp_on = 1'b0;

    d_flipflop_7bit #(.WIDTH(7), .RESET_VALUE(0)) dut (
        .clk     (clk),
        .reset   (reset),
        .d       (d),
        .en      (en),
        .clr     (clr),
        .q       (q),
        .q_valid (q_valid),
        .q_chg   (q_chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q     = 7'd0;
        m_valid = 1'b0;
        m_chg   = 1'b0;
    endtask

    // One clock cycle: inputs change mid-cycle, then the model advances at
    // the rising edge. Asserting reset checks the asynchronous response.
    task automatic cyc(input logic [6:0] nd, input logic nen, input logic nclr, input logic nrst);
        logic [6:0] nq;
        @(negedge clk);
        #2;
        d   = nd;
        en  = nen;
        clr = nclr;
        if (nrst && !reset) begin
            reset = 1'b1;
            model_reset();
            #1;
            chk("async_rst_q", 32'(q), 32'(0));
            chk("async_rst_valid", 32'(q_valid), 32'(0));
            chk("async_rst_chg", 32'(q_chg), 32'(0));
        end else if (!nrst) begin
            reset = 1'b0;
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            nq      = nclr ? 7'd0 : (nen ? nd : m_q);
            m_chg   = (nq != m_q);
            m_valid = m_valid | nclr | nen;
            m_q     = nq;
        end
        transaction_log(nd, nen, nclr, nrst);
    endtask

    task automatic transaction_log(input logic [6:0] nd, input logic nen, input logic nclr, input logic nrst);
        $display("t=%0t d=%h en=%b clr=%b rst=%b -> model q=%h valid=%b chg=%b",
                 $time, nd, nen, nclr, nrst, m_q, m_valid, m_chg);
    endtask

    // Continuous comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            checks++;
            if (q !== m_q || q_valid !== m_valid || q_chg !== m_chg) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t actual q=%h v=%b c=%b expected q=%h v=%b c=%b",
                         $time, q, q_valid, q_chg, m_q, m_valid, m_chg);
            end
        end
    end

    initial begin
        reset = 1'b0;
        d     = 7'd0;
        en    = 1'b0;
        clr   = 1'b0;
        // Reset before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("idle_rst_q", 32'(q), 32'(0));
        chk("idle_rst_valid", 32'(q_valid), 32'(0));
        chk("idle_rst_chg", 32'(q_chg), 32'(0));
        model_reset();
        cmp_on = 1'b1;

        cyc(7'h12, 1'b1, 1'b0, 1'b1);
        cyc(7'h05, 1'b1, 1'b0, 1'b0);
        #1;
        chk("first_cap_q", 32'(q), 32'h05);
        chk("first_cap_valid", 32'(q_valid), 32'(1));
        chk("first_cap_chg", 32'(q_chg), 32'(1));

        // Sequential capture.
        for (int i = 1; i <= 3; i++) begin
            cyc(7'(i), 1'b1, 1'b0, 1'b0);
            #1 chk("seq_q", 32'(q), 32'(i));
        end
        cyc(7'd3, 1'b1, 1'b0, 1'b0);
        #1 chk("seq_same_chg", 32'(q_chg), 32'(0));

        // Enable hold.
        cyc(7'h2A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(7'h11, 1'b0, 1'b0, 1'b0);
            #1;
            chk("hold_q", 32'(q), 32'h2A);
            chk("hold_chg", 32'(q_chg), 32'(0));
        end
        cyc(7'h11, 1'b1, 1'b0, 1'b0);
        #1 chk("hold_release_q", 32'(q), 32'h11);

        // Clear beats enable.
        cyc(7'h40, 1'b1, 1'b0, 1'b0);
        cyc(7'h7F, 1'b1, 1'b1, 1'b0);
        #1;
        chk("clr_q", 32'(q), 32'(0));
        chk("clr_chg", 32'(q_chg), 32'(1));
        chk("clr_valid", 32'(q_valid), 32'(1));

        // Wrap-around stored as given.
        cyc(7'h7F, 1'b1, 1'b0, 1'b0);
        #1 chk("wrap_hi_q", 32'(q), 32'h7F);
        cyc(7'h00, 1'b1, 1'b0, 1'b0);
        #1 chk("wrap_lo_q", 32'(q), 32'h00);

        // Reset mid-operation, held across two edges.
        cyc(7'h33, 1'b1, 1'b0, 1'b0);
        #1 chk("pre_rst_q", 32'(q), 32'h33);
        cyc(7'h12, 1'b1, 1'b0, 1'b1);
        cyc(7'h12, 1'b1, 1'b0, 1'b1);
        #1;
        chk("rst_held_q", 32'(q), 32'(0));
        chk("rst_held_valid", 32'(q_valid), 32'(0));

        // Randomized stimulus.
        for (int i = 0; i < 400; i++) begin
            logic [6:0] rd;
            logic       ren, rclr, rrst;
            rd   = 7'($urandom);
            ren  = ($urandom_range(0, 3) != 0);
            rclr = ($urandom_range(0, 9) == 0);
            rrst = ($urandom_range(0, 29) == 0);
            cyc(rd, ren, rclr, rrst);
        end
        cyc(7'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_flipflop_7bit.md
Name: d_flipflop_7bit

Overview:
- Program-counter state register for the CPU's PC block. Captures the next-address value on every rising clock edge and presents it as the current instruction address to the ROM.
- Width is a parameter; the default of 7 matches the PC instantiation.
- Adds a write enable, a synchronous clear, a capture-valid flag and a change strobe, so the PC can be stalled, restarted and monitored without extra glue logic.

Parameters:
- WIDTH, 7: data width of d and q.
- RESET_VALUE, 0: value loaded into q on reset and on synchronous clear. It is truncated to WIDTH bits.

Ports:
- clk      input   1      rising-edge clock
- reset    input   1      asynchronous, active-high reset
- d        input   WIDTH  next value (the PC's next_addr). The PC truncates its wider next_addr to WIDTH bits at the connection.
- en       input   1      capture enable. Tie to 1 for plain D-flip-flop use, as in the PC.
- clr      input   1      synchronous clear to RESET_VALUE. Tie to 0 when unused.
- q        output  WIDTH  registered value (the PC's current_addr)
- q_valid  output  1      0 after reset; 1 once any capture or clear edge has occurred
- q_chg    output  1      one-cycle strobe; 1 when the last clock edge changed q

Behaviour:
- Reset (reset=1, asynchronous, takes effect immediately with no clock needed):
  - q = RESET_VALUE, q_valid = 0, q_chg = 0.
  - All outputs hold these values while reset stays high; clock edges are ignored.
- Deassertion of reset is taken synchronously: the first rising edge with reset=0 performs normal operation.
- Per rising clk edge with reset=0, in priority order:
  - clr=1: q <= RESET_VALUE, q_valid <= 1. clr wins over en and d.
  - else en=1: q <= d, q_valid <= 1.
  - else: q holds; q_valid holds.
- q_chg is registered. On each edge with reset=0 it is set to (new q != old q); otherwise it is 0.
- Latency:
  - d to q: exactly one clock edge.
  - q is never combinationally dependent on d, en or clr.
- Width rules:
  - d is taken bit-for-bit; no sign extension or arithmetic happens inside the block.
  - Wrap-around of the PC (for example, 127 followed by 0) is the upstream adder's concern. It is stored as given.
- X handling: if d contains X or Z while en=1, q takes X. Verification flags this as an upstream error; there is no internal masking.
- Simultaneous events:
  - reset asserted coincident with a clock edge: reset wins.
  - clr=1 and en=1 together: clr wins.
- Reset mid-operation: q returns to RESET_VALUE within the same delta, with no clock edge required, and q_valid drops to 0.
- No internal state beyond q, q_valid and q_chg.

Test Plan:
- Reset while clk idle: reset=1 with no clock edges -> q=0, q_valid=0, q_chg=0 immediately. Release reset, then edge with en=1, d=7'h05 -> q=5, q_valid=1, q_chg=1.
- Sequential capture, with en=1, clr=0:
  - d=1,2,3 on successive edges -> q=1,2,3 one edge after each.
  - d=3 held for a further edge -> q_chg=0 on that edge.
- Enable hold: q=7'h2A, en=0, d=7'h11 for 3 edges -> q stays 7'h2A, q_chg=0. Set en=1 -> next edge q=7'h11.
- Clear priority: q=7'h40, clr=1, en=1, d=7'h7F -> next edge q=0, q_chg=1, q_valid=1.
- Wrap and truncation: d=7'h7F then d=7'h00 (PC next_addr 128 truncated) -> q=7'h7F then q=7'h00.
- Async reset mid-cycle: q=7'h33, assert reset between edges -> q=0 before the next edge. Reset high across 2 edges with d=7'h12 -> q stays 0.
